// File: rtl/gate_sweep_ctrl.sv
// Stimulus sequencer/checker for a 2-input gate with a 7-bit output bus: sweeps {a,b} and counts XNOR mismatches.
// Optional GATE_SWEEP_ABORT_EN: stop at the first mismatching vector instead of completing all sweeps.
module gate_sweep_ctrl #(
    parameter int unsigned DWELL  = 20,
    parameter int unsigned PASSES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] gate_z,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [1:0] vec_idx
);

    localparam int unsigned ZW = 7;
    localparam int unsigned EW = 4;
    localparam int unsigned VW = 2;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned SW = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SW-1:0] SWEEP_LAST = SW'(PASSES - 1);
    localparam logic [EW-1:0] ERR_MAX    = EW'(15);
    localparam logic [VW-1:0] VEC_LAST   = VW'(3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] dwell_cnt, dwell_cnt_n;
    logic [SW-1:0] sweep, sweep_n;
    logic [VW-1:0] vec_idx_n;
    logic [EW-1:0] err_count_n, err_inc;
    logic          gate_a_n, gate_b_n, busy_n, done_n, pass_n;
    logic [ZW-1:0] z_expected;
    logic          mismatch;

    // Compare against the XNOR of the vector currently applied to the gate
    always_comb begin
        z_expected = {ZW{~(gate_a ^ gate_b)}};
        mismatch   = (gate_z != z_expected);
        err_inc    = (mismatch && (err_count != ERR_MAX)) ? (err_count + EW'(1)) : err_count;
    end

    always_comb begin
        state_n     = state;
        dwell_cnt_n = dwell_cnt;
        sweep_n     = sweep;
        vec_idx_n   = vec_idx;
        err_count_n = err_count;
        gate_a_n    = gate_a;
        gate_b_n    = gate_b;
        busy_n      = busy;
        done_n      = done;
        pass_n      = pass;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n     = DRIVE;
                    dwell_cnt_n = '0;
                    sweep_n     = '0;
                    vec_idx_n   = '0;
                    err_count_n = '0;
                    busy_n      = 1'b1;
                    done_n      = 1'b0;
                    pass_n      = 1'b0;
                end
            end
            DRIVE: begin
                if (dwell_cnt == DWELL_LAST) begin
                    state_n     = SAMPLE;
                    dwell_cnt_n = '0;
                end else begin
                    dwell_cnt_n = dwell_cnt + DW'(1);
                end
            end
            SAMPLE: begin
                err_count_n = err_inc;
`ifdef GATE_SWEEP_ABORT_EN
                if (mismatch) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = 1'b0;
                end else
`endif
                if (vec_idx != VEC_LAST) begin
                    state_n   = DRIVE;
                    vec_idx_n = vec_idx + VW'(1);
                end else if (sweep != SWEEP_LAST) begin
                    state_n   = DRIVE;
                    vec_idx_n = '0;
                    sweep_n   = sweep + SW'(1);
                end else begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_inc == '0);
                end
            end
            default: state_n = IDLE;
        endcase

        // Gate inputs follow the vector on every DRIVE entry; otherwise they hold
        if (state_n == DRIVE) begin
            {gate_a_n, gate_b_n} = vec_idx_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            sweep     <= '0;
            vec_idx   <= '0;
            err_count <= '0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_n;
            dwell_cnt <= dwell_cnt_n;
            sweep     <= sweep_n;
            vec_idx   <= vec_idx_n;
            err_count <= err_count_n;
            gate_a    <= gate_a_n;
            gate_b    <= gate_b_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: three instances (DWELL/PASSES = 4/2, 1/1, 4/10) driven by a table-based gate model.
// Expected latency/err_count/pass come from a sweep-level reference model.
module tb_gate_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start     [3];
    logic [6:0] gate_z    [3];
    logic       gate_a    [3];
    logic       gate_b    [3];
    logic       busy      [3];
    logic       done      [3];
    logic       pass      [3];
    logic [3:0] err_count [3];
    logic [1:0] vec_idx   [3];
    logic [6:0] ztab      [3][4];

    int total = 0;
    int bad   = 0;

    gate_sweep_ctrl #(.DWELL(4), .PASSES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .gate_z(gate_z[0]),
        .gate_a(gate_a[0]), .gate_b(gate_b[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err_count[0]), .vec_idx(vec_idx[0]));

    gate_sweep_ctrl #(.DWELL(1), .PASSES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .gate_z(gate_z[1]),
        .gate_a(gate_a[1]), .gate_b(gate_b[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err_count[1]), .vec_idx(vec_idx[1]));

    gate_sweep_ctrl #(.DWELL(4), .PASSES(10)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .gate_z(gate_z[2]),
        .gate_a(gate_a[2]), .gate_b(gate_b[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_count(err_count[2]), .vec_idx(vec_idx[2]));

    // Gate under test: combinational lookup of z per {a,b}
    assign gate_z[0] = ztab[0][{gate_a[0], gate_b[0]}];
    assign gate_z[1] = ztab[1][{gate_a[1], gate_b[1]}];
    assign gate_z[2] = ztab[2][{gate_a[2], gate_b[2]}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dw_of(input int u);
        return (u == 1) ? 1 : 4;
    endfunction

    function automatic int ps_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 10);
    endfunction

    function automatic logic [6:0] good_z(input int v);
        return (v == 0 || v == 3) ? 7'h7F : 7'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int u);
        chk("rst_gate_a", 32'(gate_a[u]), 32'd0);
        chk("rst_gate_b", 32'(gate_b[u]), 32'd0);
        chk("rst_vec",    32'(vec_idx[u]), 32'd0);
        chk("rst_busy",   32'(busy[u]), 32'd0);
        chk("rst_done",   32'(done[u]), 32'd0);
        chk("rst_pass",   32'(pass[u]), 32'd0);
        chk("rst_err",    32'(err_count[u]), 32'd0);
    endtask

    // Full run from a start pulse (or held start), with expectations from the sweep model
    task automatic run_dut(input int u, input logic [6:0] t [4], input bit hold);
        int d, p, errs, fail_j, lat, exp_err, exp_vec, n, ev;
        bit got;
        bit mis [4];
        d      = dw_of(u);
        p      = ps_of(u);
        errs   = 0;
        fail_j = -1;
        for (int v = 0; v < 4; v++) begin
            mis[v]     = (t[v] != good_z(v));
            ztab[u][v] = t[v];
        end
        for (int j = 0; j < p * 4; j++) begin
            if (mis[j % 4]) begin
                errs++;
                if (fail_j < 0) fail_j = j;
            end
        end
`ifdef GATE_SWEEP_ABORT_EN
        if (fail_j >= 0) begin
            lat     = 1 + (fail_j + 1) * (d + 1);
            exp_err = 1;
            exp_vec = fail_j % 4;
        end else
`endif
        begin
            lat     = 1 + p * 4 * (d + 1);
            exp_err = (errs > 15) ? 15 : errs;
            exp_vec = 3;
        end

        start[u] = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < lat + 20) begin
            step();
            n++;
            if (!hold) start[u] = 1'b0;
            if (done[u] === 1'b1) begin
                got = 1'b1;
            end else begin
                ev = ((n - 1) / (d + 1)) % 4;
                chk("busy_vec", 32'({busy[u], gate_a[u], gate_b[u], vec_idx[u]}),
                    32'({1'b1, 2'(ev), 2'(ev)}));
            end
        end
        chk("done_lat", got ? 32'(n) : 32'hFFFF_FFFF, 32'(lat));
        chk("end_err",  32'(err_count[u]), 32'(exp_err));
        chk("end_pass", 32'(pass[u]), 32'(exp_err == 0));
        chk("end_vec",  32'(vec_idx[u]), 32'(exp_vec));
        chk("end_gate", 32'({gate_a[u], gate_b[u]}), 32'(exp_vec));
        chk("end_busy", 32'(busy[u]), 32'd0);
    endtask

    initial begin
        logic [6:0] tv [4];
        logic [6:0] ok_t [4];
        logic [6:0] stuck [4];
        int k;

        ok_t  = '{7'h7F, 7'h00, 7'h00, 7'h7F};
        stuck = '{7'h00, 7'h00, 7'h00, 7'h00};
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            start[u] = 1'b0;
            for (int v = 0; v < 4; v++) ztab[u][v] = ok_t[v];
        end
        #3;
        for (int u = 0; u < 3; u++) chk_reset(u);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Correct gate, stuck-at-0 gate, single-bit fault with saturation, minimum dwell
        run_dut(0, ok_t, 1'b0);
        step();
        run_dut(0, stuck, 1'b0);
        step();
        for (int v = 0; v < 4; v++) tv[v] = ok_t[v] ^ 7'h08;
        run_dut(2, tv, 1'b0);
        step();
        run_dut(1, ok_t, 1'b0);
        step();

        // Asynchronous reset in the middle of sweep 1, vector 2
        for (int v = 0; v < 4; v++) ztab[0][v] = ok_t[v];
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 1; i < 31; i++) step();
        chk("mid_vec", 32'({busy[0], vec_idx[0]}), 32'({1'b1, 2'd2}));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_dut(0, ok_t, 1'b0);
        step();

        // start held through a run, then restart from DONE on the following edge
        run_dut(0, stuck, 1'b1);
        step();
        chk("rs_done", 32'(done[0]), 32'd0);
        chk("rs_busy", 32'(busy[0]), 32'd1);
        chk("rs_err",  32'(err_count[0]), 32'd0);
        chk("rs_vec",  32'({gate_a[0], gate_b[0], vec_idx[0]}), 32'd0);
        start[0] = 1'b0;
        for (int v = 0; v < 4; v++) ztab[0][v] = ok_t[v];
        k = 0;
        while (done[0] !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        chk("rs_fin_lat",  32'(k), 32'd40);
        chk("rs_fin_pass", 32'({pass[0], err_count[0]}), 32'({1'b1, 4'd0}));
        step();

        // Randomized fault tables on every instance
        for (int r = 0; r < 12; r++) begin
            for (int v = 0; v < 4; v++)
                tv[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : good_z(v);
            run_dut(r % 3, tv, 1'b0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
